// File: rtl/rr_arbiter8_pkg.sv
// Shared types, sizes and the round-robin pick function for the 8-way arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Rotate so that ptr lands on bit 0, then take the lowest set bit and undo the rotation.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end else begin
                off = off;
            end
        end
        return ptr + off;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester/resource-side bundle of the 8-way arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter8_decoder3_8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder3_8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);

    // Enabled one-hot decode of the 3-bit index.
    always_comb begin
        y = 8'h00;
        if (en) begin
            y[a] = 1'b1;
        end else begin
            y = 8'h00;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; a grant is held until done, owner
// abandonment, or MAX_HOLD cycles of tenure (0 disables the limit).
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);

    localparam int                CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic              TO_EN    = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(MAX_HOLD);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    logic             w_rel_done;
    logic             w_rel_aband;
    logic             w_rel_to;
    logic             w_release;
    logic [N_REQ-1:0] w_gnt;

    assign w_rel_done  = bus.done;
    assign w_rel_aband = ~bus.req[r_gnt_idx];
    assign w_rel_to    = TO_EN && (r_hold_cnt == HOLD_LIM);
    assign w_release   = w_rel_done | w_rel_aband | w_rel_to;

    // Arbitration state machine with registered grant and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= {IDX_W{1'b0}};
            r_gnt_idx   <= {IDX_W{1'b0}};
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= {CNT_W{1'b0}};
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (bus.req != {N_REQ{1'b0}}) begin
                        r_gnt_idx   <= rr_pick(bus.req, r_ptr);
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= CNT_W'(1);
                        r_state     <= GRANT;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_idx + 3'd1;
                        r_state     <= IDLE;
                        // Pulse only when the tenure limit alone forced the release.
                        r_timeout   <= w_rel_to & ~w_rel_done & ~w_rel_aband;
                    end else begin
                        r_timeout   <= 1'b0;
                        if (r_hold_cnt != {CNT_W{1'b1}}) begin
                            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                        end else begin
                            r_hold_cnt <= r_hold_cnt;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    decoder3_8 u_dec (
        .en (r_gnt_valid),
        .a  (r_gnt_idx),
        .y  (w_gnt)
    );

    assign bus.gnt       = w_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (MAX_HOLD=4): a behavioural model queues the
// expected outputs per driven cycle; directed checks cover the listed scenarios.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic clk;
    logic rst;
    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int   m_state;  // 0 idle, 1 grant
    int   m_ptr;
    int   m_idx;
    int   m_hold;
    logic m_valid;
    logic m_to;

    logic [12:0] sb_q[$];
    logic [7:0]  obs_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] rq, input logic d);
        logic rd, ra, rt;
        if (r) begin
            m_state = 0; m_ptr = 0; m_idx = 0; m_hold = 0; m_valid = 1'b0; m_to = 1'b0;
        end else if (m_state == 0) begin
            m_to = 1'b0;
            if (rq != 8'h00) begin
                for (int k = 7; k >= 0; k--) begin
                    if (rq[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
                end
                m_valid = 1'b1;
                m_hold  = 1;
                m_state = 1;
            end
        end else begin
            rd = d;
            ra = !rq[m_idx];
            rt = (MH != 0) && (m_hold == MH);
            if (rd || ra || rt) begin
                m_valid = 1'b0;
                m_ptr   = (m_idx + 1) % 8;
                m_state = 0;
                m_to    = rt && !rd && !ra;
            end else begin
                m_to   = 1'b0;
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic d);
        logic [12:0] e;
        logic [7:0]  eg;
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.done = d;
        model_step(r, rq, d);
        eg = m_valid ? (8'h01 << m_idx) : 8'h00;
        sb_q.push_back({eg, 3'(m_idx), m_valid, m_to});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_gnt", {24'h0, bus.gnt}, {24'h0, e[12:5]});
        chk("sb_valid", {31'h0, bus.gnt_valid}, {31'h0, e[1]});
        chk("sb_timeout", {31'h0, bus.timeout}, {31'h0, e[0]});
        if (e[1]) chk("sb_idx", {29'h0, bus.gnt_idx}, {29'h0, e[4:2]});
        obs_gnt = bus.gnt;
    endtask

    initial begin
        logic [7:0] rq;
        rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
        m_state = 0; m_ptr = 0; m_idx = 0; m_hold = 0; m_valid = 1'b0; m_to = 1'b0;

        // reset with all requests active
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        chk("rst_gnt", {24'h0, bus.gnt}, 32'h0);
        chk("rst_valid", {31'h0, bus.gnt_valid}, 32'h0);
        chk("rst_timeout", {31'h0, bus.timeout}, 32'h0);
        step(1'b0, 8'hFF, 1'b0);
        chk("rst_first_gnt", {24'h0, obs_gnt}, 32'h01);

        // rotation with done on each grant's 2nd cycle
        for (int g = 0; g < 9; g++) begin
            chk("rot_gnt", {24'h0, obs_gnt}, 32'h1 << (g % 8));
            step(1'b0, 8'hFF, 1'b0);
            step(1'b0, 8'hFF, 1'b1);
            chk("rot_idle", {24'h0, obs_gnt}, 32'h0);
            step(1'b0, 8'hFF, 1'b0);
        end

        // wrap and skip
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        chk("wrap_g6", {24'h0, obs_gnt}, 32'h40);
        step(1'b0, 8'h40, 1'b1);
        step(1'b0, 8'h05, 1'b0);
        chk("wrap_g0", {24'h0, obs_gnt}, 32'h01);
        step(1'b0, 8'h05, 1'b1);
        step(1'b0, 8'h05, 1'b0);
        chk("skip_g2", {24'h0, obs_gnt}, 32'h04);
        step(1'b0, 8'h05, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // timeout after MAX_HOLD cycles, then re-grant
        step(1'b0, 8'h08, 1'b0);
        chk("to_gnt_c1", {24'h0, obs_gnt}, 32'h08);
        for (int c = 2; c <= MH; c++) begin
            step(1'b0, 8'h08, 1'b0);
            chk("to_gnt_hold", {24'h0, obs_gnt}, 32'h08);
        end
        step(1'b0, 8'h08, 1'b0);
        chk("to_pulse", {31'h0, bus.timeout}, 32'h1);
        chk("to_idle", {24'h0, obs_gnt}, 32'h0);
        step(1'b0, 8'h08, 1'b0);
        chk("to_regrant", {24'h0, obs_gnt}, 32'h08);
        chk("to_single", {31'h0, bus.timeout}, 32'h0);

        // done coincides with the limit: no pulse
        for (int c = 2; c <= MH; c++) step(1'b0, 8'h08, 1'b0);
        step(1'b0, 8'h08, 1'b1);
        chk("sim_valid", {31'h0, bus.gnt_valid}, 32'h0);
        chk("sim_timeout", {31'h0, bus.timeout}, 32'h0);

        // owner abandons mid-grant
        step(1'b0, 8'h08, 1'b0);
        step(1'b0, 8'h08, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("aband_valid", {31'h0, bus.gnt_valid}, 32'h0);

        // mid-grant reset, then ptr back at 0
        step(1'b0, 8'hFF, 1'b0);
        chk("mrst_pre", {24'h0, obs_gnt}, 32'h10);
        step(1'b1, 8'hFF, 1'b0);
        chk("mrst_gnt", {24'h0, obs_gnt}, 32'h0);
        chk("mrst_timeout", {31'h0, bus.timeout}, 32'h0);
        step(1'b0, 8'hFF, 1'b0);
        chk("mrst_ptr0", {24'h0, obs_gnt}, 32'h01);

        // done while idle with no requests is ignored
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("idle_done", {31'h0, bus.gnt_valid}, 32'h0);
        step(1'b0, 8'h02, 1'b0);
        chk("idle_done_next", {24'h0, obs_gnt}, 32'h02);

        // random traffic against the model
        rq = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
            step(($urandom_range(0, 60) == 0), rq, ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among 8 requesters and holds each grant until its owner releases it. The grant is registered as a 3-bit index plus valid flag. The one-hot grant vector is produced by a `decoder3_8` instance, enabled by the valid flag. Sits between the requester agents and the shared resource's select lines.

## Interface
- `MAX_HOLD`, default 16: maximum grant tenure in cycles before forced release; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 8: request vector, bit i = requester i; level-sensitive.
- `done` in 1: release strobe from the current owner; sampled only in GRANT.
- `gnt` out 8: one-hot grant, decoded from `gnt_idx` gated by `gnt_valid`; all-zero when idle.
- `gnt_idx` out 3: index of the current owner; valid only when `gnt_valid`=1.
- `gnt_valid` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- States: IDLE, GRANT.
- Registers:
  - `ptr` [2:0]: round-robin start point.
  - `gnt_idx`, `gnt_valid`.
  - `hold_cnt`, width `$clog2(MAX_HOLD+1)` (min 1).
  - `timeout`.
- IDLE:
  - If `req` != 0, select the first set bit searching upward from `ptr`, wrapping 7→0.
  - Load `gnt_idx`, set `gnt_valid`=1, `hold_cnt`=1, go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT: release when any of the following holds.
  - (a) `done`=1.
  - (b) `req[gnt_idx]`=0 (owner abandoned).
  - (c) `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`.
- On release:
  - `gnt_valid`←0, `ptr`←`gnt_idx`+1 (mod 8, wraps 7→0), go to IDLE.
  - `hold_cnt` is not cleared (don't-care in IDLE).
  - `gnt_idx` keeps its last value.
- Otherwise `hold_cnt` increments; it saturates, never wraps.
- `timeout` pulses for 1 cycle only when (c) is the sole release cause; (a) or (b) together with (c) → no pulse.
- `done` in IDLE is ignored.
- `req` changes on non-owner bits during GRANT are ignored; no preemption.
- `gnt` = `decoder3_8(en=gnt_valid, A=gnt_idx)`, so it is always one-hot or zero.
- Reset values:
  - state=IDLE, `ptr`=0, `gnt_idx`=0, `gnt_valid`=0, `hold_cnt`=0, `timeout`=0, hence `gnt`=8'h00.
- Reset asserted mid-grant: the grant drops on the next edge and no `timeout` pulse is produced.

## Timing
- Request latency: `req` sampled at edge N in IDLE → `gnt`/`gnt_valid` high after edge N. `gnt` is combinational from registers, so the decode adds no cycle.
- Release latency: release condition sampled at edge M → `gnt_valid`=0 after edge M.
  - One mandatory idle cycle (bus turnaround).
  - Next grant is visible after edge M+1 at the earliest.
- Tenure: a grant lasts at most `MAX_HOLD` cycles. With `MAX_HOLD`=16, `gnt` is high for exactly 16 cycles; `timeout` is high in the first idle cycle.
- `timeout` is registered and coincides with the first cycle of `gnt_valid`=0.

## Structure
- Package `arb_pkg`:
  - `N_REQ`=8, `IDX_W`=3.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Function `rr_pick(req, ptr)` returning the index of the first set bit at or after `ptr`.
- Sub-module: one `decoder3_8` instance for the one-hot `gnt`; no other hierarchy.
- `rr_pick` is a rotate-then-priority-encode over 8 bits; pure combinational logic inside the function.

## Test plan
- Reset: hold `rst` 2 cycles with `req`=8'hFF → `gnt`=8'h00, `gnt_valid`=0, `timeout`=0; after release, `gnt`=8'h01 one cycle later.
- Rotation: `req`=8'hFF held, `done` pulsed on each grant's 2nd cycle → `gnt` sequence 01,02,04,…,80,01 with one idle cycle between grants.
- Wrap and skip: release a grant to index 6 (`ptr`→7), then `req`=8'h05 → `gnt`=8'h01; after its release, `gnt`=8'h04.
- Timeout: `MAX_HOLD`=4, `req`=8'h08, no `done` → `gnt`=8'h08 for 4 cycles, then `timeout`=1 for 1 cycle, then re-grant to 8'h08.
- Simultaneous release: `done`=1 on the cycle `hold_cnt`==`MAX_HOLD` → release with `timeout`=0. Owner drops `req` mid-grant → `gnt_valid`=0 next cycle.
- Mid-grant reset plus ignored inputs: assert `rst` during a grant → next cycle `gnt`=0, `ptr`=0. `done`=1 in IDLE with `req`=0 → no state change.
